// File: rtl/rc4_encrypt_fsm.sv
// RC4 PRGA encryptor. It walks a prepared S array held in an external
// single-port RAM and XORs each keystream byte with a plaintext byte.
// Each ciphertext byte is written to a single-port RAM.
// All outputs are registered and decoded from the next state, so every
// output is aligned with the state that owns it.
module rc4_encrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_q,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        pt_q,
  output logic [MSG_AW-1:0] pt_address,
  output logic [MSG_AW-1:0] ct_address,
  output logic [7:0]        ct_data,
  output logic              ct_wren,
  output logic              finish
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] INC_I  = 4'd1;
  localparam logic [3:0] RD_SI  = 4'd2;
  localparam logic [3:0] WT_SI  = 4'd3;
  localparam logic [3:0] CALC_J = 4'd4;
  localparam logic [3:0] RD_SJ  = 4'd5;
  localparam logic [3:0] WT_SJ  = 4'd6;
  localparam logic [3:0] WR_SI  = 4'd7;
  localparam logic [3:0] WR_SJ  = 4'd8;
  localparam logic [3:0] RD_F   = 4'd9;
  localparam logic [3:0] WT_F   = 4'd10;
  localparam logic [3:0] WR_CT  = 4'd11;
  localparam logic [3:0] NEXT   = 4'd12;
  localparam logic [3:0] DONE   = 4'd13;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  logic [3:0]        state_reg, state_next;
  logic [7:0]        i_reg, i_next;
  logic [7:0]        j_reg, j_next;
  logic [7:0]        si_reg, si_next;
  logic [7:0]        sj_reg, sj_next;
  logic [7:0]        f_reg, f_next;
  logic [7:0]        pt_reg, pt_next;
  logic [MSG_AW-1:0] k_reg, k_next;

  logic [7:0]        s_address_next;
  logic [7:0]        s_data_next;
  logic              s_wren_next;
  logic [MSG_AW-1:0] pt_address_next;
  logic [MSG_AW-1:0] ct_address_next;
  logic [7:0]        ct_data_next;
  logic              ct_wren_next;
  logic              finish_next;

  // State sequencing and datapath updates for the current state.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    f_next     = f_reg;
    pt_next    = pt_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        i_next = 8'd0;
        j_next = 8'd0;
        k_next = '0;
        if (start) state_next = INC_I;
      end
      INC_I: begin
        i_next     = i_reg + 8'd1;
        state_next = RD_SI;
      end
      RD_SI:  state_next = WT_SI;
      WT_SI: begin
        si_next    = s_q;
        state_next = CALC_J;
      end
      CALC_J: begin
        j_next     = j_reg + si_reg;
        state_next = RD_SJ;
      end
      RD_SJ:  state_next = WT_SJ;
      WT_SJ: begin
        sj_next    = s_q;
        state_next = WR_SI;
      end
      WR_SI:  state_next = WR_SJ;
      WR_SJ:  state_next = RD_F;
      RD_F:   state_next = WT_F;
      WT_F: begin
        f_next     = s_q;
        pt_next    = pt_q;
        state_next = WR_CT;
      end
      WR_CT:  state_next = NEXT;
      NEXT: begin
        if (k_reg == K_LAST) begin
          state_next = DONE;
        end else begin
          k_next     = k_reg + MSG_AW'(1);
          state_next = INC_I;
        end
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the state being entered, so they appear with it.
  always_comb begin
    s_address_next  = 8'd0;
    s_data_next     = 8'd0;
    s_wren_next     = 1'b0;
    pt_address_next = '0;
    ct_address_next = '0;
    ct_data_next    = 8'd0;
    ct_wren_next    = 1'b0;
    finish_next     = 1'b0;
    case (state_next)
      RD_SI: s_address_next = i_next;
      RD_SJ: s_address_next = j_next;
      WR_SI: begin
        s_address_next = i_next;
        s_data_next    = sj_next;
        s_wren_next    = 1'b1;
      end
      WR_SJ: begin
        // When i == j this second write lands on the same cell and leaves
        // the original S[i] there, which is the intended swap result.
        s_address_next = j_next;
        s_data_next    = si_next;
        s_wren_next    = 1'b1;
      end
      RD_F: begin
        s_address_next  = si_next + sj_next;
        pt_address_next = k_next;
      end
      WR_CT: begin
        ct_address_next = k_next;
        ct_data_next    = f_next ^ pt_next;
        ct_wren_next    = 1'b1;
      end
      DONE: finish_next = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers; reset drops every output at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      i_reg      <= 8'd0;
      j_reg      <= 8'd0;
      si_reg     <= 8'd0;
      sj_reg     <= 8'd0;
      f_reg      <= 8'd0;
      pt_reg     <= 8'd0;
      k_reg      <= '0;
      s_address  <= 8'd0;
      s_data     <= 8'd0;
      s_wren     <= 1'b0;
      pt_address <= '0;
      ct_address <= '0;
      ct_data    <= 8'd0;
      ct_wren    <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      i_reg      <= i_next;
      j_reg      <= j_next;
      si_reg     <= si_next;
      sj_reg     <= sj_next;
      f_reg      <= f_next;
      pt_reg     <= pt_next;
      k_reg      <= k_next;
      s_address  <= s_address_next;
      s_data     <= s_data_next;
      s_wren     <= s_wren_next;
      pt_address <= pt_address_next;
      ct_address <= ct_address_next;
      ct_data    <= ct_data_next;
      ct_wren    <= ct_wren_next;
      finish     <= finish_next;
    end
  end

endmodule
